// File: rtl/vol_sci_writer_pkg.sv
// Shared constants and state type for the VS10xx SCI volume writer.
// Frame layout on the wire: opcode, register address, 16-bit data, MSB first.
package vol_sci_writer_pkg;

    localparam logic [7:0] SCI_WRITE_OP   = 8'h02;
    localparam logic [7:0] SCI_VOL_ADDR   = 8'h0B;
    localparam int         SCI_FRAME_BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DREQ,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic logic [31:0] sci_frame(input logic [7:0] addr, input logic [15:0] data);
        return {SCI_WRITE_OP, addr, data};
    endfunction

endpackage

// File: rtl/vol_sci_writer_if.sv
// Bundle between the volume stage, the SCI writer and the decoder pins.
// DREQ is the only flow control: a frame starts only on a cycle where the writer
// is waiting and DREQ=1; once started, a frame runs to completion regardless of DREQ.
interface vol_sci_writer_if;

    logic [15:0] VOL;
    logic        DREQ;
    logic        XCS;
    logic        SCLK;
    logic        SI;
    logic        BUSY;
    logic        DONE;

    modport master (
        input  VOL, DREQ,
        output XCS, SCLK, SI, BUSY, DONE
    );

    modport slave (
        output VOL, DREQ,
        input  XCS, SCLK, SI, BUSY, DONE
    );

endinterface

// File: rtl/vol_sci_writer_sci_clk_div.sv
// Half-period tick generator for SCLK: one-cycle tick every CLK_DIV enabled cycles.
// The count is held at zero while disabled, so every frame starts with a full phase.
module sci_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int             W    = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/vol_sci_writer.sv
// Watches VOL and writes every change to the decoder's SCI_VOL register as one
// 32-bit SCI frame; changes arriving mid-frame collapse into a single follow-up.
module vol_sci_writer
    import vol_sci_writer_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [7:0] SCI_ADDR = SCI_VOL_ADDR,
    parameter int         CS_GAP   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    vol_sci_writer_if.master  sci,
    output state_t            dbg_state
);

    state_t      state, state_d;
    logic [31:0] shreg, shreg_d;
    logic [5:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  gap_cnt, gap_cnt_d;
    logic        pending, pending_d;
    logic [15:0] last_vol, last_vol_d;
    logic        xcs, xcs_d;
    logic        sclk, sclk_d;
    logic        busy, busy_d;
    logic        done, done_d;
    logic        div_en, tick;

    assign div_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    sci_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (CLK),
        .rst  (RST),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            pending  <= 1'b1;
            last_vol <= '0;
            xcs      <= 1'b1;
            sclk     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            gap_cnt  <= gap_cnt_d;
            pending  <= pending_d;
            last_vol <= last_vol_d;
            xcs      <= xcs_d;
            sclk     <= sclk_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        gap_cnt_d  = gap_cnt;
        last_vol_d = last_vol;
        xcs_d      = xcs;
        sclk_d     = sclk;
        busy_d     = busy;
        done_d     = 1'b0;
        // Pending is only ever cleared by starting a frame, never by VOL matching again.
        pending_d  = pending || (sci.VOL != last_vol);

        case (state)
            IDLE: begin
                if (pending) begin
                    state_d = WAIT_DREQ;
                    busy_d  = 1'b1;
                end
            end
            WAIT_DREQ: begin
                if (sci.DREQ) begin
                    shreg_d    = sci_frame(SCI_ADDR, sci.VOL);
                    last_vol_d = sci.VOL;
                    pending_d  = 1'b0;
                    xcs_d      = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The low phase after the last bit still belongs to SHIFT; HOLD follows it.
                if (tick) begin
                    if (sclk) begin
                        sclk_d    = 1'b0;
                        shreg_d   = {shreg[30:0], 1'b0};
                        bit_cnt_d = bit_cnt + 6'd1;
                    end else if (bit_cnt == 6'(SCI_FRAME_BITS)) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    xcs_d     = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sci.XCS  = xcs;
    assign sci.SCLK = sclk;
    assign sci.SI   = shreg[31];
    assign sci.BUSY = busy;
    assign sci.DONE = done;
    assign dbg_state = state;

endmodule
